// File: rtl/popcount_window_stats_pkg.sv
// Shared types and width helpers for the popcount pipeline
// (bit_population_counter and its window statistics consumer).
package popcount_pkg;

   typedef enum logic {
      OUT_IDLE  = 1'b0,
      OUT_VALID = 1'b1
   } out_state_t;

   // Popcount of a WIDTH-bit word spans 0..WIDTH inclusive.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

   // Exact width for the sum of win_len popcounts, so it can never overflow.
   function automatic int sum_width(input int width, input int win_len);
      return $clog2(width * win_len + 1);
   endfunction

endpackage

// File: rtl/popcount_window_stats_accum.sv
// Window sample counter with running sum/min/max. It emits done together
// with the final values, which already include the completing sample.
module popcount_window_accum
   import popcount_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int WIN_LEN = 16,
   localparam int CNT_W  = cnt_width(WIDTH),
   localparam int SUM_W  = sum_width(WIDTH, WIN_LEN)
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic             accept_i,
   input  logic             clear_i,
   input  logic [CNT_W-1:0] data_i,
   output logic             at_last_o,
   output logic             done_o,
   output logic [SUM_W-1:0] sum_o,
   output logic [CNT_W-1:0] min_o,
   output logic [CNT_W-1:0] max_o
);

   localparam int IDX_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(WIN_LEN - 1);

   logic [IDX_W-1:0] cnt;
   logic [SUM_W-1:0] sum_q;
   logic [CNT_W-1:0] min_q;
   logic [CNT_W-1:0] max_q;
   logic             first;

   assign first     = (cnt == '0);
   assign at_last_o = (cnt == LAST);
   assign done_o    = accept_i & at_last_o & ~clear_i;

   // The first sample of a window loads directly, so stale accumulators never leak in.
   always_comb begin
      sum_o = first ? SUM_W'(data_i) : sum_q + SUM_W'(data_i);
      min_o = (first || data_i < min_q) ? data_i : min_q;
      max_o = (first || data_i > max_q) ? data_i : max_q;
   end

   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         cnt   <= '0;
         sum_q <= '0;
         min_q <= '0;
         max_q <= '0;
      end else if (clear_i || done_o) begin
         cnt   <= '0;
         sum_q <= '0;
         min_q <= '0;
         max_q <= '0;
      end else if (accept_i) begin
         cnt   <= cnt + IDX_W'(1);
         sum_q <= sum_o;
         min_q <= min_o;
         max_q <= max_o;
      end
   end

endmodule

// File: rtl/popcount_window_stats.sv
// Per-window sum/min/max of popcount samples, with one result per window
// published over a valid/ready handshake.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never waits on ready, and a held result stays stable.
module popcount_window_stats
   import popcount_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int WIN_LEN = 16,
   localparam int CNT_W  = cnt_width(WIDTH),
   localparam int SUM_W  = sum_width(WIDTH, WIN_LEN)
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic [CNT_W-1:0] data_i,
   input  logic             data_val_i,
   output logic             data_ready_o,
   input  logic             clear_i,
   output logic [SUM_W-1:0] sum_o,
   output logic [CNT_W-1:0] min_o,
   output logic [CNT_W-1:0] max_o,
   output logic             stat_val_o,
   input  logic             stat_ready_i,
   output out_state_t       state_o
);

   out_state_t       state;
   out_state_t       state_nxt;
   logic             accept;
   logic             at_last;
   logic             done;
   logic [SUM_W-1:0] fin_sum;
   logic [CNT_W-1:0] fin_min;
   logic [CNT_W-1:0] fin_max;

   // Only the sample that would overwrite an unconsumed result is stalled.
   assign data_ready_o = ~srst_i & ~(stat_val_o & ~stat_ready_i & at_last);
   assign accept       = data_val_i & data_ready_o;
   assign stat_val_o   = (state == OUT_VALID);
   assign state_o      = state;

   popcount_window_accum #(
      .WIDTH   (WIDTH),
      .WIN_LEN (WIN_LEN)
   ) u_accum (
      .clk_i     (clk_i),
      .srst_i    (srst_i),
      .accept_i  (accept),
      .clear_i   (clear_i),
      .data_i    (data_i),
      .at_last_o (at_last),
      .done_o    (done),
      .sum_o     (fin_sum),
      .min_o     (fin_min),
      .max_o     (fin_max)
   );

   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         state <= OUT_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         OUT_IDLE:  if (done) state_nxt = OUT_VALID;
         OUT_VALID: if (stat_ready_i && !done) state_nxt = OUT_IDLE;
         default:   state_nxt = OUT_IDLE;
      endcase
   end

   // A completion can only occur when no result is held or it is being consumed.
   always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
         sum_o <= '0;
         min_o <= '0;
         max_o <= '0;
      end else if (done) begin
         sum_o <= fin_sum;
         min_o <= fin_min;
         max_o <= fin_max;
      end
   end

endmodule

// File: tb/tb_popcount_window_stats.sv
// Self-checking bench: a queue-based window model checked every cycle,
// a result scoreboard, and directed literal expectations.
module tb_popcount_window_stats;
   import popcount_pkg::*;

   localparam int WIDTH   = 8;
   localparam int WIN_LEN = 4;
   localparam int CNT_W   = cnt_width(WIDTH);
   localparam int SUM_W   = sum_width(WIDTH, WIN_LEN);
   localparam int SUM1_W  = sum_width(WIDTH, 1);
   localparam int E_W     = SUM_W + 2 * CNT_W;

   // ---------------- clock / reset ----------------
   logic clk  = 1'b0;
   logic srst = 1'b1;
   always #5 clk = ~clk;

   logic [CNT_W-1:0]  data       = '0;
   logic              data_val   = 1'b0;
   logic              clear      = 1'b0;
   logic              stat_ready = 1'b0;
   logic              data_ready;
   logic              stat_val;
   logic [SUM_W-1:0]  sum;
   logic [CNT_W-1:0]  min_v;
   logic [CNT_W-1:0]  max_v;
   out_state_t        state;

   logic              stat_ready1 = 1'b1;
   logic              data_ready1;
   logic              stat_val1;
   logic [SUM1_W-1:0] sum1;
   logic [CNT_W-1:0]  min1;
   logic [CNT_W-1:0]  max1;
   out_state_t        state1;

   popcount_window_stats #(.WIDTH(WIDTH), .WIN_LEN(WIN_LEN)) dut (
      .clk_i        (clk),
      .srst_i       (srst),
      .data_i       (data),
      .data_val_i   (data_val),
      .data_ready_o (data_ready),
      .clear_i      (clear),
      .sum_o        (sum),
      .min_o        (min_v),
      .max_o        (max_v),
      .stat_val_o   (stat_val),
      .stat_ready_i (stat_ready),
      .state_o      (state)
   );

   popcount_window_stats #(.WIDTH(WIDTH), .WIN_LEN(1)) dut1 (
      .clk_i        (clk),
      .srst_i       (srst),
      .data_i       (data),
      .data_val_i   (data_val),
      .data_ready_o (data_ready1),
      .clear_i      (clear),
      .sum_o        (sum1),
      .min_o        (min1),
      .max_o        (max1),
      .stat_val_o   (stat_val1),
      .stat_ready_i (stat_ready1),
      .state_o      (state1)
   );

   int checks   = 0;
   int failures = 0;
   bit rand_rdy = 0;
   bit sb_on    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int unsigned win_q[$];
   bit          m_val  = 0;
   int          m_sum  = 0;
   int          m_min  = 0;
   int          m_max  = 0;
   bit          m1_val = 0;
   int          m1_d   = 0;
   logic [E_W-1:0] exp_q[$];

   function automatic bit m_ready();
      return !srst && !(m_val && !stat_ready && win_q.size() == WIN_LEN - 1);
   endfunction

   always @(posedge clk or posedge srst) begin : model
      bit acc;
      if (srst) begin
         win_q.delete();
         m_val  = 0;
         m1_val = 0;
      end else begin
         acc = data_val && m_ready();
         if (m_val && stat_ready) m_val = 0;
         if (clear) begin
            win_q.delete();
         end else if (acc) begin
            win_q.push_back(int'(data));
            if (win_q.size() == WIN_LEN) begin
               m_sum = 0;
               m_min = WIDTH;
               m_max = 0;
               foreach (win_q[i]) begin
                  m_sum += win_q[i];
                  if (win_q[i] < m_min) m_min = win_q[i];
                  if (win_q[i] > m_max) m_max = win_q[i];
               end
               m_val = 1;
               win_q.delete();
            end
         end
         m1_val = data_val && !clear;
         if (m1_val) m1_d = int'(data);
      end
   end

   always @(posedge clk) begin
      if (!srst && data_val) assert (data <= WIDTH) else $error("illegal sample %0d", data);
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (srst) begin
         chk("ready_in_reset", data_ready, 0);
         chk("ready1_in_reset", data_ready1, 0);
      end else begin
         chk("data_ready", data_ready, m_ready());
         chk("stat_val", stat_val, m_val);
         chk("state", state, m_val ? OUT_VALID : OUT_IDLE);
         if (m_val) begin
            chk("sum", sum, m_sum);
            chk("min", min_v, m_min);
            chk("max", max_v, m_max);
         end
         chk("data_ready1", data_ready1, 1);
         chk("stat_val1", stat_val1, m1_val);
         if (m1_val) begin
            chk("sum1", sum1, m1_d);
            chk("min1", min1, m1_d);
            chk("max1", max1, m1_d);
         end
         if (sb_on && stat_val && stat_ready) begin
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               logic [E_W-1:0] e;
               e = exp_q.pop_front();
               chk("sb_sum", sum, e[E_W-1 -: SUM_W]);
               chk("sb_min", min_v, e[2*CNT_W-1 -: CNT_W]);
               chk("sb_max", max_v, e[CNT_W-1:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int d);
      bit ok;
      int n;
      data     = CNT_W'(d);
      data_val = 1'b1;
      n        = 0;
      do begin
         if (rand_rdy) begin
            stat_ready = 1'($urandom_range(0, 1));
            #1;
         end
         ok = data_ready;
         step();
         n++;
      end while (!ok && n < 100);
      if (!ok) chk("send_timeout", 0, 1);
      data_val = 1'b0;
   endtask

   task automatic idle(input int n);
      data_val = 1'b0;
      repeat (n) begin
         if (rand_rdy) stat_ready = 1'($urandom_range(0, 1));
         step();
      end
   endtask

   task automatic chk_out(input string name, input int s, input int mn, input int mx);
      chk({name, "_val"}, stat_val, 1);
      chk({name, "_sum"}, sum, s);
      chk({name, "_min"}, min_v, mn);
      chk({name, "_max"}, max_v, mx);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      step();
      step();
      chk("rst_sum", sum, 0);
      chk("rst_min", min_v, 0);
      chk("rst_max", max_v, 0);
      chk("rst_val", stat_val, 0);
      srst = 1'b0;
      step();

      // async reset between edges, mid-window
      stat_ready = 1'b1;
      send(3);
      send(5);
      #2 srst = 1'b1;
      #2;
      chk("arst_sum", sum, 0);
      chk("arst_val", stat_val, 0);
      chk("arst_ready", data_ready, 0);
      srst = 1'b0;
      step();
      send(1); send(1); send(1); send(1);
      chk_out("t1", 4, 1, 1);

      // back-to-back window
      send(3); send(5); send(0); send(8);
      chk_out("t2", 16, 0, 8);

      // held result stalls only the overwriting sample
      step();
      stat_ready = 1'b0;
      send(3); send(5); send(0); send(8);
      chk_out("t3a", 16, 0, 8);
      send(1); send(1); send(1);
      data     = 4'd2;
      data_val = 1'b1;
      #1 chk("t3_stall", data_ready, 0);
      step();
      step();
      chk_out("t3_hold", 16, 0, 8);
      stat_ready = 1'b1;
      #1 chk("t3_release", data_ready, 1);
      step();
      data_val = 1'b0;
      chk_out("t3b", 5, 1, 2);

      // clear drops the window in progress and the sample beside it
      step();
      send(7); send(7);
      data     = 4'd6;
      data_val = 1'b1;
      clear    = 1'b1;
      step();
      clear    = 1'b0;
      data_val = 1'b0;
      send(2); send(2); send(2); send(2);
      chk_out("t4", 8, 2, 2);

      // gaps and random backpressure, scoreboarded
      step();
      sb_on    = 1;
      rand_rdy = 1;
      for (int w = 0; w < 12; w++) begin
         exp_q.push_back({SUM_W'(16), CNT_W'(0), CNT_W'(8)});
         idle($urandom_range(0, 3)); send(3);
         idle($urandom_range(0, 3)); send(5);
         idle($urandom_range(0, 3)); send(0);
         idle($urandom_range(0, 3)); send(8);
      end
      rand_rdy   = 0;
      stat_ready = 1'b1;
      repeat (3) step();
      chk("sb_drained", exp_q.size(), 0);
      sb_on = 0;

      // single-sample windows
      for (int i = 0; i < 9; i++) begin
         send((i % 3) * 4);
         chk("t6_val1", stat_val1, 1);
         chk("t6_sum1", sum1, (i % 3) * 4);
         chk("t6_min1", min1, (i % 3) * 4);
         chk("t6_max1", max1, (i % 3) * 4);
      end

      // random data, gaps, backpressure and occasional clears
      rand_rdy = 1;
      for (int i = 0; i < 300; i++) begin
         idle($urandom_range(0, 2));
         if ($urandom_range(0, 19) == 0) begin
            data     = CNT_W'($urandom_range(0, WIDTH));
            data_val = 1'($urandom_range(0, 1));
            clear    = 1'b1;
            step();
            clear    = 1'b0;
            data_val = 1'b0;
         end else begin
            send($urandom_range(0, WIDTH));
         end
      end
      rand_rdy   = 0;
      stat_ready = 1'b1;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
